// File: rtl/accum_warp_serializer_if.sv
// Warp-in / serial-address-out bus for accum_warp_serializer.
// slave is the serializer's view; master is the upstream source plus downstream sink.
interface accum_warp_serializer_if #(
    parameter int unsigned VSIZE = 32,
    parameter int unsigned AW    = 16
);
    localparam int unsigned LW = $clog2(VSIZE);

    logic                  av_rdy;
    logic                  av_ack;
    logic [VSIZE*AW-1:0]   av_addr;
    logic [VSIZE-1:0]      av_mask;
    logic                  av_last;

    logic                  sa_rdy;
    logic                  sa_ack;
    logic [AW-1:0]         sa_addr;
    logic [LW-1:0]         sa_lane;
    logic                  sa_last;

    modport master (
        output av_rdy, av_addr, av_mask, av_last, sa_ack,
        input  av_ack, sa_rdy, sa_addr, sa_lane, sa_last
    );

    modport slave (
        input  av_rdy, av_addr, av_mask, av_last, sa_ack,
        output av_ack, sa_rdy, sa_addr, sa_lane, sa_last
    );
endinterface

// File: rtl/accum_warp_serializer.sv
// Serializes a warp of lane addresses into one beat per cycle, lowest valid lane first.
// Define ACCUM_WARP_SERIALIZER_DUPSKIP_EN to drop lanes repeating the previously emitted address.
module accum_warp_serializer #(
    parameter int unsigned VSIZE = 32,
    parameter int unsigned AW    = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    accum_warp_serializer_if.slave bus,
    output logic                   o_done
);
    localparam int unsigned LW = $clog2(VSIZE);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e              state_q, state_d;
    logic [VSIZE*AW-1:0] addr_q, addr_d;
    logic [VSIZE-1:0]    pend_q, pend_d;
    logic                last_q, last_d;
    logic                done_q, done_d;

    logic [VSIZE-1:0]    cur_onehot;
    logic [VSIZE-1:0]    pend_next;
    logic [LW-1:0]       cur_lane;
    logic [AW-1:0]       cur_addr;
    logic                found;
    logic                is_last_beat;
    logic                beat_taken;
    logic                accept;

    // Lowest pending lane is the one on the bus.
    always_comb begin
        cur_onehot = '0;
        cur_lane   = '0;
        cur_addr   = '0;
        found      = 1'b0;
        for (int unsigned k = 0; k < VSIZE; k++) begin
            if (pend_q[k] && !found) begin
                found         = 1'b1;
                cur_onehot[k] = 1'b1;
                cur_lane      = LW'(k);
                cur_addr      = addr_q[k*AW +: AW];
            end
        end
    end

`ifdef ACCUM_WARP_SERIALIZER_DUPSKIP_EN
    logic dropping;

    // Lanes directly following the current one with the same address vanish together with it.
    always_comb begin
        pend_next = pend_q & ~cur_onehot;
        dropping  = 1'b1;
        for (int unsigned k = 0; k < VSIZE; k++) begin
            if (pend_next[k] && dropping) begin
                if (addr_q[k*AW +: AW] == cur_addr) begin
                    pend_next[k] = 1'b0;
                end else begin
                    dropping = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        pend_next = pend_q & ~cur_onehot;
    end
`endif

    always_comb begin
        is_last_beat = (pend_next == '0);
        bus.sa_rdy   = (state_q == StShift);
        bus.sa_addr  = cur_addr;
        bus.sa_lane  = cur_lane;
        bus.sa_last  = bus.sa_rdy && last_q && is_last_beat;
        beat_taken   = bus.sa_rdy && bus.sa_ack;
        bus.av_ack   = i_rst && bus.av_rdy &&
                       ((state_q == StIdle) || (beat_taken && is_last_beat));
        accept       = bus.av_ack;
        o_done       = done_q;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        last_d  = last_q;
        done_d  = (beat_taken && bus.sa_last) ||
                  (accept && (bus.av_mask == '0) && bus.av_last);

        unique case (state_q)
            StIdle: ;
            StShift: begin
                if (beat_taken) begin
                    pend_d = pend_next;
                    if (is_last_beat) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A warp accepted on the final beat replaces the drained one with no bubble.
        if (accept) begin
            addr_d  = bus.av_addr;
            pend_d  = bus.av_mask;
            last_d  = bus.av_last;
            state_d = (bus.av_mask != '0) ? StShift : StIdle;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            pend_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_accum_warp_serializer.sv
// Bench for accum_warp_serializer: directed and random warps checked against a beat-queue model.
module tb_accum_warp_serializer;
    localparam int unsigned VSIZE = 8;
    localparam int unsigned AW    = 8;

    typedef struct {
        logic [2:0] lane;
        logic [7:0] addr;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        done;
    logic        ack_en;
    int unsigned ack_mode;
    beat_t       exp_q[$];
    logic        done_exp;
    logic        rst_low_prev;
    logic        exp_ack;
    int          n_checks;
    int          n_fail;
    int          n_beats;
    logic [63:0] addr_v;
    logic [7:0]  mask_v;

    accum_warp_serializer_if #(.VSIZE(VSIZE), .AW(AW)) bus ();

    accum_warp_serializer #(
        .VSIZE (VSIZE),
        .AW    (AW)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .bus    (bus),
        .o_done (done)
    );

    always #5 clk = ~clk;

    // The sink only acknowledges while a beat is offered.
    assign bus.sa_ack = ack_en & bus.sa_rdy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected beats of one warp: valid lanes in ascending order, last flag on the final one.
    task automatic model_warp(input logic [63:0] addr, input logic [7:0] mask, input logic last);
        beat_t b;
        int    first = exp_q.size();
`ifdef ACCUM_WARP_SERIALIZER_DUPSKIP_EN
        logic [7:0] prev = 8'h00;
        bit         have_prev = 1'b0;
`endif
        for (int k = 0; k < 8; k++) begin
            if (mask[k]) begin
                b.lane = 3'(k);
                b.addr = addr[k*8 +: 8];
                b.last = 1'b0;
`ifdef ACCUM_WARP_SERIALIZER_DUPSKIP_EN
                if (have_prev && b.addr == prev) continue;
                prev      = b.addr;
                have_prev = 1'b1;
`endif
                exp_q.push_back(b);
            end
        end
        if (exp_q.size() > first && last) exp_q[exp_q.size()-1].last = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("rst_av_ack", bus.av_ack, 1'b0);
            if (rst_low_prev) begin
                check_eq("rst_sa_rdy", bus.sa_rdy, 1'b0);
                check_eq("rst_sa_last", bus.sa_last, 1'b0);
                check_eq("rst_o_done", done, 1'b0);
            end
            exp_q.delete();
            done_exp     = 1'b0;
            rst_low_prev = 1'b1;
        end else begin
            rst_low_prev = 1'b0;
            check_eq("o_done", done, done_exp);
            done_exp = 1'b0;
            check_eq("sa_rdy", bus.sa_rdy, exp_q.size() != 0);
            exp_ack = bus.av_rdy && (exp_q.size() == 0 || (bus.sa_ack && exp_q.size() == 1));
            check_eq("av_ack", bus.av_ack, exp_ack);
            if (exp_q.size() != 0) begin
                check_eq("sa_lane", bus.sa_lane, exp_q[0].lane);
                check_eq("sa_addr", bus.sa_addr, exp_q[0].addr);
                check_eq("sa_last", bus.sa_last, exp_q[0].last);
                if (bus.sa_ack) begin
                    if (exp_q[0].last) done_exp = 1'b1;
                    void'(exp_q.pop_front());
                    n_beats++;
                end
            end
            if (bus.av_rdy && bus.av_ack) begin
                model_warp(bus.av_addr, bus.av_mask, bus.av_last);
                if (bus.av_mask == 8'h00 && bus.av_last) done_exp = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0:       ack_en = 1'b1;
            1:       ack_en = ~ack_en;
            default: ack_en = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic logic [63:0] ramp(input logic [7:0] base);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = base + 8'(k);
        return r;
    endfunction

    task automatic send_warp(input logic [63:0] addr, input logic [7:0] mask, input logic last);
        int t = 0;
        bus.av_rdy  = 1'b1;
        bus.av_addr = addr;
        bus.av_mask = mask;
        bus.av_last = last;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.av_ack && t < 300);
        check_eq("accept_in_time", bus.av_ack, 1'b1);
        @(posedge clk);
        #1;
        bus.av_rdy = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || bus.sa_rdy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain_in_time", exp_q.size() == 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        int n0;
        int t;
        rst          = 1'b0;
        ack_mode     = 0;
        ack_en       = 1'b1;
        bus.av_rdy   = 1'b0;
        bus.av_addr  = '0;
        bus.av_mask  = '0;
        bus.av_last  = 1'b0;
        n_checks     = 0;
        n_fail       = 0;
        n_beats      = 0;
        done_exp     = 1'b0;
        rst_low_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Sparse mask, full-rate sink.
        send_warp(ramp(8'h10), 8'b1010_0101, 1'b1);
        wait_drain();

        // Back-to-back full warps.
        send_warp(ramp(8'h20), 8'hFF, 1'b0);
        send_warp(ramp(8'h40), 8'hFF, 1'b1);
        wait_drain();

        // Stalling sink.
        ack_mode = 1;
        send_warp(ramp(8'h50), 8'hFF, 1'b1);
        wait_drain();
        ack_mode = 0;

        // Empty warps.
        send_warp(ramp(8'h60), 8'h00, 1'b1);
        wait_drain();
        send_warp(ramp(8'h60), 8'h00, 1'b0);
        wait_drain();

        // Reset mid-warp, then a fresh warp.
        n0 = n_beats;
        send_warp(ramp(8'h70), 8'hFF, 1'b1);
        t = 0;
        while (n_beats < n0 + 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("two_beats_before_reset", n_beats - n0, 2);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        send_warp(ramp(8'h80), 8'hFF, 1'b1);
        wait_drain();

        // Repeated addresses.
        send_warp({8{8'h33}}, 8'hFF, 1'b1);
        wait_drain();

        ack_mode = 2;
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 1) == 0) addr_v[k*8 +: 8] = 8'h30 + 8'($urandom_range(0, 2));
                else addr_v[k*8 +: 8] = 8'($urandom);
            end
            mask_v = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            send_warp(addr_v, mask_v, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
